// File: rtl/sensor_adc_sequencer_if.sv
// Sensor / ADC control bus used by sensor_adc_sequencer.
//
// Signals:
//   sens_config             [2:0]  sensor configuration, held between measurements
//   sens_enable                    sensor power/enable
//   sens_read                      sensor read strobe
//   adc_enable                     ADC enable
//   adc_read                       ADC conversion-start strobe
//   adc_conversion_complete        ADC handshake back to the sequencer
//   adc_value               [15:0] ADC conversion data
//
// Modports:
//   master  sequencer side (drives controls, receives ADC handshake/data)
//   slave   sensor/ADC side
interface sensor_adc_sequencer_if;
   logic [2:0]  sens_config;
   logic        sens_enable;
   logic        sens_read;
   logic        adc_enable;
   logic        adc_read;
   logic        adc_conversion_complete;
   logic [15:0] adc_value;

   modport master (
      output sens_config,
      output sens_enable,
      output sens_read,
      output adc_enable,
      output adc_read,
      input  adc_conversion_complete,
      input  adc_value
   );

   modport slave (
      input  sens_config,
      input  sens_enable,
      input  sens_read,
      input  adc_enable,
      input  adc_read,
      output adc_conversion_complete,
      output adc_value
   );
endinterface

// File: rtl/sensor_adc_sequencer.sv
// Sensor/ADC measurement sequencer.
//
// On an accepted start the sensor configuration is latched, the sensor and
// ADC are enabled and allowed to settle, a read strobe is issued and the
// sequencer waits (bounded by a timeout) for the ADC to report completion.
// The captured value (or a timeout indication) is published with a
// single-cycle result_valid pulse, after which the enables are dropped.
//
// Optional feature macro: SENS_ADC_AVERAGING_EN
//   defined   -> four READ/WAIT sequences per measurement, summed into an
//                18-bit accumulator; result is the truncated mean acc[17:2].
//   undefined -> single conversion; result is the captured adc_value.
//
// Parameters:
//   SETTLE_TICKS   cycles the enables are held before the read (1..255)
//   TIMEOUT_TICKS  max cycles spent in WAIT (2..65535)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   start          single-cycle measurement request (ignored unless idle)
//   cfg      [2:0] sensor configuration, sampled on an accepted start
//   busy           measurement in progress
//   result_valid   single-cycle pulse when result/timeout_err update
//   result  [15:0] last good measurement
//   timeout_err    last measurement timed out
//   adc_bus        sensor/ADC control bus (master modport)
module sensor_adc_sequencer #(
   parameter int unsigned SETTLE_TICKS  = 16,
   parameter int unsigned TIMEOUT_TICKS = 4096
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [2:0]                      cfg,
   output logic                            busy,
   output logic                            result_valid,
   output logic [15:0]                     result,
   output logic                            timeout_err,
   sensor_adc_sequencer_if.master          adc_bus
);

   // state  | meaning
   // IDLE   | waiting for start, enables low
   // SETTLE | enables high, counting down the settle time
   // READ   | one-cycle sens_read/adc_read strobe
   // WAIT   | waiting for conversion complete, bounded by timeout
   // DONE   | publish result/timeout, drop enables, back to IDLE
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      READ   = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_TICKS - 1);
   localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT_TICKS - 1);

   state_t      state_q, state_d;
   logic [7:0]  settle_cnt_q, settle_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timed_out_q, timed_out_d;
   logic        busy_q, busy_d;
   logic        rv_q, rv_d;
   logic [15:0] result_q, result_d;
   logic        err_q, err_d;
   logic [2:0]  cfg_q, cfg_d;
   logic        en_q, en_d;
   logic        rd_q, rd_d;

`ifdef SENS_ADC_AVERAGING_EN
   logic [17:0] acc_q, acc_d;
   logic [1:0]  samp_q, samp_d;
`else
   logic [15:0] cap_q, cap_d;
`endif

   // Next-state and next-output logic. Every output is a register, so the
   // values computed here appear one cycle after the deciding edge.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      timed_out_d  = timed_out_q;
      busy_d       = busy_q;
      rv_d         = 1'b0;
      result_d     = result_q;
      err_d        = err_q;
      cfg_d        = cfg_q;
      en_d         = en_q;
      rd_d         = 1'b0;
`ifdef SENS_ADC_AVERAGING_EN
      acc_d        = acc_q;
      samp_d       = samp_q;
`else
      cap_d        = cap_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = SETTLE;
               cfg_d        = cfg;
               busy_d       = 1'b1;
               en_d         = 1'b1;
               settle_cnt_d = SETTLE_LOAD;
               wait_cnt_d   = 16'd0;
               timed_out_d  = 1'b0;
`ifdef SENS_ADC_AVERAGING_EN
               acc_d        = 18'd0;
               samp_d       = 2'd0;
`endif
            end
         end

         SETTLE: begin
            if (settle_cnt_q == 8'd0) begin
               state_d = READ;
               rd_d    = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q - 8'd1;
            end
         end

         READ: begin
            state_d    = WAIT;
            wait_cnt_d = 16'd0;
         end

         WAIT: begin
            // Completion is checked first so it wins over a same-cycle timeout.
            if (adc_bus.adc_conversion_complete) begin
`ifdef SENS_ADC_AVERAGING_EN
               acc_d = acc_q + {2'b00, adc_bus.adc_value};
               if (samp_q == 2'd3) begin
                  state_d = DONE;
               end else begin
                  samp_d  = samp_q + 2'd1;
                  state_d = READ;
                  rd_d    = 1'b1;
               end
`else
               cap_d   = adc_bus.adc_value;
               state_d = DONE;
`endif
            end else if (wait_cnt_q == WAIT_LAST) begin
               timed_out_d = 1'b1;
               state_d     = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
            rv_d    = 1'b1;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            err_d   = timed_out_q;
            if (!timed_out_q) begin
`ifdef SENS_ADC_AVERAGING_EN
               result_d = acc_q[17:2];
`else
               result_d = cap_q;
`endif
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         settle_cnt_q <= 8'd0;
         wait_cnt_q   <= 16'd0;
         timed_out_q  <= 1'b0;
         busy_q       <= 1'b0;
         rv_q         <= 1'b0;
         result_q     <= 16'h0000;
         err_q        <= 1'b0;
         cfg_q        <= 3'b000;
         en_q         <= 1'b0;
         rd_q         <= 1'b0;
`ifdef SENS_ADC_AVERAGING_EN
         acc_q        <= 18'd0;
         samp_q       <= 2'd0;
`else
         cap_q        <= 16'h0000;
`endif
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         timed_out_q  <= timed_out_d;
         busy_q       <= busy_d;
         rv_q         <= rv_d;
         result_q     <= result_d;
         err_q        <= err_d;
         cfg_q        <= cfg_d;
         en_q         <= en_d;
         rd_q         <= rd_d;
`ifdef SENS_ADC_AVERAGING_EN
         acc_q        <= acc_d;
         samp_q       <= samp_d;
`else
         cap_q        <= cap_d;
`endif
      end
   end

   assign busy                = busy_q;
   assign result_valid        = rv_q;
   assign result              = result_q;
   assign timeout_err         = err_q;
   assign adc_bus.sens_config = cfg_q;
   assign adc_bus.sens_enable = en_q;
   assign adc_bus.adc_enable  = en_q;
   assign adc_bus.sens_read   = rd_q;
   assign adc_bus.adc_read    = rd_q;

endmodule

// File: doc/sensor_adc_sequencer.md
SENSOR_ADC_SEQUENCER -- requirements
Module: sensor_adc_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_TICKS, default 16, giving the number of clk cycles the sensor/ADC enables are held before a read (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 4096, giving the maximum number of clk cycles spent waiting for conversion complete (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: 13.56MHz carrier-recovered clock, the only clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request from the adapter to perform a measurement.
REQ-006 SHALL have port cfg, input, 3 bits: sensor configuration, sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until the cycle before the return to IDLE, inclusive.
REQ-008 SHALL have port result_valid, output, 1 bit: single-cycle pulse when result or timeout_err is updated.
REQ-009 SHALL have port result, output, 16 bits: last measurement, held until the next result_valid.
REQ-010 SHALL have port timeout_err, output, 1 bit: set when the last measurement timed out, cleared on a good result.
REQ-011 SHALL have ports sens_config (output, 3 bits), sens_enable (output, 1 bit), sens_read (output, 1 bit), adc_enable (output, 1 bit) and adc_read (output, 1 bit): registered sensor/ADC controls.
REQ-012 SHALL have ports adc_conversion_complete (input, 1 bit) and adc_value (input, 16 bits): ADC handshake input and data.

Function
REQ-013 SHALL implement the FSM states IDLE, SETTLE, READ, WAIT and DONE, with all outputs registered.
REQ-014 In IDLE, start=1 SHALL latch cfg into sens_config and move to SETTLE; sens_enable and adc_enable SHALL be high from the next cycle.
REQ-015 SETTLE SHALL last exactly SETTLE_TICKS cycles and then go to READ.
REQ-016 READ SHALL last 1 cycle with sens_read=adc_read=1, then go to WAIT with the timeout counter cleared.
REQ-017 In WAIT, adc_conversion_complete=1 SHALL capture adc_value and move to DONE; complete SHALL be ignored in every other state.
REQ-018 WAIT SHALL time out when the counter reaches TIMEOUT_TICKS-1 with complete low; on timeout it SHALL set timeout_err=1, leave result unchanged and go to DONE.
REQ-019 If complete and timeout expiry occur in the same cycle, completion SHALL win.
REQ-020 DONE SHALL last 1 cycle: result_valid=1, busy=0, both enables driven low on the next edge, then go to IDLE.
REQ-021 start while not in IDLE SHALL be ignored (not queued).
REQ-022 Latency from start to result_valid SHALL be SETTLE_TICKS+3+N cycles, where N is the number of WAIT cycles up to and including the complete cycle.
REQ-023 sens_config SHALL hold its value between measurements and change only on an accepted start.

Reset
REQ-024 rst_n=0 SHALL immediately force the following: state IDLE; busy, result_valid, timeout_err, sens_enable, adc_enable, sens_read and adc_read all 0; result 16'h0000; sens_config 3'b000; all counters 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no result_valid pulse; after release the block SHALL accept start on the first cycle.

Configuration
REQ-026 With the macro SENS_ADC_AVERAGING_EN defined, each measurement SHALL perform 4 READ/WAIT sequences, returning to READ with no re-settle, and sum the samples into an 18-bit accumulator; result SHALL be acc[17:2] (truncated mean).
REQ-027 With SENS_ADC_AVERAGING_EN defined, a timeout on any of the 4 sequences SHALL abort the measurement to DONE with timeout_err=1 and result unchanged.
REQ-028 With SENS_ADC_AVERAGING_EN undefined, the block SHALL perform a single conversion and result SHALL equal the captured adc_value; no accumulator logic SHALL be present.

Verification
REQ-029 The bench SHALL cover a single measurement: SETTLE_TICKS=4, cfg=3'b101, start, complete in the 3rd WAIT cycle with adc_value=16'hBEEF -> sens_config=101, one read pulse, result=BEEF, result_valid 10 cycles after start, timeout_err=0.
REQ-030 The bench SHALL cover timeout: TIMEOUT_TICKS=8 with complete never asserted -> result_valid after 8 WAIT cycles, timeout_err=1, result unchanged, enables low.
REQ-031 The bench SHALL cover simultaneous events: complete in the same cycle as timeout expiry with value 16'h0001 -> result=0001, timeout_err=0.
REQ-032 The bench SHALL cover start during busy and stray complete: start pulses in SETTLE and WAIT, complete asserted in SETTLE -> exactly one result_valid, and the SETTLE-phase complete is ignored.
REQ-033 The bench SHALL cover reset mid-WAIT: rst_n low for 1 cycle -> all outputs at reset values, no result_valid, and a new start is accepted immediately after release.
REQ-034 The bench SHALL cover averaging with SENS_ADC_AVERAGING_EN defined: samples FFFF, FFFF, FFFF, FFFD -> result=16'hFFFE, 4 read pulses, 1 result_valid.
